// File: rtl/compress_sched_pkg.sv
// compress_sched_pkg: shared types and constants for the tile compression scheduler
package compress_sched_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, DONE, IDLE} sched_state_t;
    localparam int SCHED_ID_W = 3;
endpackage

// File: rtl/compress_sched_if.sv
// compress_sched_if: request, pipeline-issue, result and response signals of the scheduler
//   master: scheduler side (drives req_ready, cmp_*, rsp_*)
//   slave : requester/pipeline side (drives req_*, cmp_ready, res_*)
interface compress_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cmp_valid;
    logic [ADDR_W-1:0]         cmp_addr;
    logic                      cmp_ready;
    logic                      res_valid;
    logic                      res_compressable;
    logic [1:0]                res_flag;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      rsp_compressable;
    logic [1:0]                rsp_flag;
    modport master (
        input  req_valid, req_addr, cmp_ready, res_valid, res_compressable, res_flag,
        output req_ready, cmp_valid, cmp_addr, rsp_valid, rsp_compressable, rsp_flag
    );
    modport slave (
        output req_valid, req_addr, cmp_ready, res_valid, res_compressable, res_flag,
        input  req_ready, cmp_valid, cmp_addr, rsp_valid, rsp_compressable, rsp_flag
    );
endinterface

// File: rtl/compress_sched_id_fifo.sv
// sched_id_fifo: synchronous FIFO holding requester IDs of in-flight tiles
//   clk/rst : clock, asynchronous active-high reset
//   push/din: write an entry (ignored when full)
//   pop/dout: read the head entry (ignored when empty); dout shows the head
//   full/empty/count: occupancy
module sched_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/compress_sched.sv
// compress_sched: round-robin scheduler sharing one tile compression pipeline among NUM_REQ requesters
//   clk/rst    : clock, asynchronous active-high reset
//   bus        : compress_sched_if.master (requests, pipeline issue, commit results, responses)
//   flush      : level-sensitive drain request
//   flush_done : one-cycle pulse when the drain completes
//   busy       : tiles in flight or not in RUN
//   err        : sticky, a result arrived with nothing in flight
//   stat_*     : saturating event counters, present only with COMPRESS_SCHED_STATS_EN defined
module compress_sched
    import compress_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    compress_sched_if.master        bus,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    busy,
    output logic                    err
`ifdef COMPRESS_SCHED_STATS_EN
    ,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_compressed,
    output logic [31:0]             stat_raw
`endif
);
    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    sched_state_t state;
    logic [SCHED_ID_W-1:0] rr_ptr, win, head;
    logic any, eligible, hs, pop, full, empty, drained;
    logic [CW-1:0] count;
    int j;
    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            j = j >= NUM_REQ ? j - NUM_REQ : j;
            if (!any && bus.req_valid[j]) begin
                any = 1'b1;
                win = SCHED_ID_W'(j);
            end
        end
    end
    // flush blocks grants in the very cycle it rises, before the state moves to DRAIN.
    assign eligible      = state == RUN && !flush && !full;
    assign bus.cmp_valid = eligible && any;
    assign bus.cmp_addr  = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
    assign hs            = bus.cmp_valid && bus.cmp_ready;
    assign bus.req_ready = hs ? NUM_REQ'(1) << win : '0;
    assign pop           = bus.res_valid && !empty;
    assign drained       = count == '0 || (count == CW'(1) && pop);
    assign busy          = count != '0 || state != RUN;
    sched_id_fifo #(.DEPTH(MAX_INFLIGHT), .WIDTH(SCHED_ID_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .din   (win),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= RUN;
            rr_ptr               <= '0;
            bus.rsp_valid        <= '0;
            bus.rsp_compressable <= 1'b0;
            bus.rsp_flag         <= '0;
            flush_done           <= 1'b0;
            err                  <= 1'b0;
        end else begin
            if (hs) rr_ptr <= win == SCHED_ID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
            bus.rsp_valid <= pop ? NUM_REQ'(1) << head : '0;
            if (pop) begin
                bus.rsp_compressable <= bus.res_compressable;
                bus.rsp_flag         <= bus.res_flag;
            end
            err        <= err || (bus.res_valid && empty);
            flush_done <= state == DRAIN && drained;
            case (state)
                RUN:     state <= flush ? DRAIN : RUN;
                DRAIN:   state <= drained ? DONE : DRAIN;
                DONE:    state <= flush ? IDLE : RUN;
                default: state <= flush ? IDLE : RUN;
            endcase
        end
    end
`ifdef COMPRESS_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued     <= '0;
            stat_compressed <= '0;
            stat_raw        <= '0;
        end else begin
            if (hs && stat_issued != '1) stat_issued <= stat_issued + 1'b1;
            if (|bus.rsp_valid && bus.rsp_compressable && stat_compressed != '1)
                stat_compressed <= stat_compressed + 1'b1;
            if (|bus.rsp_valid && !bus.rsp_compressable && stat_raw != '1)
                stat_raw <= stat_raw + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_compress_sched.sv
// tb_compress_sched: directed self-checking bench for compress_sched with a response scoreboard
module tb_compress_sched;
    localparam int N  = 4;
    localparam int AW = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic flush_done, busy, err;
    int compared = 0;
    int mismatched = 0;
    logic [AW-1:0] addrs [N];
    logic [6:0] sb [$];
    int iss_q [$];
    always #5 clk = ~clk;
    compress_sched_if #(.NUM_REQ(N), .ADDR_W(AW)) bus ();
`ifdef COMPRESS_SCHED_STATS_EN
    logic [31:0] stat_issued, stat_compressed, stat_raw;
`endif
    compress_sched #(.NUM_REQ(N), .ADDR_W(AW), .MAX_INFLIGHT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .err        (err)
`ifdef COMPRESS_SCHED_STATS_EN
        ,
        .stat_issued     (stat_issued),
        .stat_compressed (stat_compressed),
        .stat_raw        (stat_raw)
`endif
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic put(input int k, input logic [AW-1:0] a);
        addrs[k] = a;
        bus.req_addr[k*AW +: AW] = a;
    endtask
    task automatic grant(input int k);
        logic [N-1:0] one;
        #1;
        one = N'(1) << k;
        chk("grant", bus.req_ready, one);
        chk("cmp_valid", bus.cmp_valid, 1);
        chk("cmp_addr", bus.cmp_addr, addrs[k]);
        iss_q.push_back(k);
        tick();
    endtask
    task automatic expect_res(input logic c, input logic [1:0] f);
        int id;
        logic [N-1:0] one;
        bus.res_valid = 1'b1;
        bus.res_compressable = c;
        bus.res_flag = f;
        if (iss_q.size() > 0) begin
            id = iss_q.pop_front();
            one = N'(1) << id;
            sb.push_back({one, c, f});
        end
    endtask
    task automatic result(input logic c, input logic [1:0] f);
        expect_res(c, f);
        tick();
        bus.res_valid = 1'b0;
    endtask
    // Every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid !== '0) begin
            if (sb.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
            else begin
                logic [6:0] e;
                e = sb.pop_front();
                chk("rsp_valid", bus.rsp_valid, e[6:3]);
                chk("rsp_comp", bus.rsp_compressable, e[2]);
                chk("rsp_flag", bus.rsp_flag, e[1:0]);
            end
        end
    end
    initial begin
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.cmp_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_compressable = 1'b0;
        bus.res_flag = '0;
        for (int k = 0; k < N; k++) put(k, 32'h1000 + 32'h40 * k);
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_cmp_valid", bus.cmp_valid, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        // single requester 2
        put(2, 32'h100);
        bus.req_valid = 4'b0100;
        bus.cmp_ready = 1'b1;
        grant(2);
        bus.req_valid = '0;
        chk("t1_busy", busy, 1);
        repeat (2) tick();
        result(1'b1, 2'b01);
        chk("t1_rsp", bus.rsp_valid, 4'b0100);
        chk("t1_flag", bus.rsp_flag, 2'b01);
        tick();
        chk("t1_rsp_gone", bus.rsp_valid, 0);
        chk("t1_idle", busy, 0);
        // all requesters, fill to MAX_INFLIGHT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        put(2, 32'h1080);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < N; k++) grant(k);
        #1;
        chk("full_ready", bus.req_ready, 0);
        chk("full_cmp_valid", bus.cmp_valid, 0);
        expect_res(1'b0, 2'b11);
        #1;
        chk("full_pop_ready", bus.req_ready, 0);
        tick();
        bus.res_valid = 1'b0;
        grant(0);
        bus.req_valid = '0;
        result(1'b1, 2'b00);
        result(1'b0, 2'b10);
        result(1'b1, 2'b11);
        result(1'b0, 2'b01);
        // pipeline stall with requesters 1 and 3
        bus.cmp_ready = 1'b0;
        bus.req_valid = 4'b1010;
        repeat (5) begin
            #1;
            chk("stall_ready", bus.req_ready, 0);
            chk("stall_cmp_valid", bus.cmp_valid, 1);
            tick();
        end
        bus.cmp_ready = 1'b1;
        grant(1);
        bus.req_valid = 4'b1000;
        grant(3);
        bus.req_valid = '0;
        result(1'b1, 2'b10);
        result(1'b0, 2'b00);
        // flush with three tiles in flight
        bus.req_valid = 4'b0111;
        grant(0);
        bus.req_valid = 4'b0110;
        grant(1);
        bus.req_valid = 4'b0100;
        grant(2);
        bus.req_valid = 4'b1111;
        flush = 1'b1;
        #1;
        chk("flush_block", bus.req_ready, 0);
        chk("flush_cmp_valid", bus.cmp_valid, 0);
        tick();
        chk("drain_ready", bus.req_ready, 0);
        result(1'b1, 2'b01);
        chk("drain_no_done", flush_done, 0);
        result(1'b0, 2'b10);
        result(1'b1, 2'b11);
        chk("flush_done", flush_done, 1);
        tick();
        chk("flush_done_pulse", flush_done, 0);
        chk("idle_busy", busy, 1);
        chk("idle_ready", bus.req_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("idle_still_blocked", bus.req_ready, 0);
        tick();
        grant(3);
        bus.req_valid = '0;
        result(1'b0, 2'b01);
        // simultaneous push and pop at inflight 2
        bus.req_valid = 4'b0001;
        grant(0);
        bus.req_valid = 4'b0010;
        grant(1);
        bus.req_valid = 4'b0100;
        expect_res(1'b0, 2'b10);
        #1;
        chk("both_grant", bus.req_ready, 4'b0100);
        iss_q.push_back(2);
        tick();
        bus.res_valid = 1'b0;
        bus.req_valid = '0;
        result(1'b1, 2'b11);
        chk("both_busy", busy, 1);
        result(1'b0, 2'b00);
        chk("both_drained", busy, 0);
        // result with nothing in flight
        result(1'b1, 2'b01);
        chk("err_set", err, 1);
        chk("err_no_rsp", bus.rsp_valid, 0);
        repeat (3) tick();
        chk("err_sticky", err, 1);
        rst = 1'b1;
        #1;
        chk("err_cleared", err, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/compress_sched.md
Name: compress_sched

Overview:
- Round-robin scheduler that shares one tile compression pipeline (header -> residual -> compress -> commit) among NUM_REQ requesters.
- Each request is one 32-pixel RGBA tile, identified by its base address.
- Issues tiles to the pipeline with a valid/ready handshake and tracks in-flight tiles in an ID FIFO.
- Routes each in-order commit result back to the requester that issued the tile; supports flush/drain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, tile base address width.
- MAX_INFLIGHT, 4, maximum tiles in the pipeline; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester tile request.
- req_addr  in  NUM_REQ*ADDR_W  per-requester tile base address; requester i uses slice i.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- cmp_valid  out  1  tile issued to pipeline.
- cmp_addr  out  ADDR_W  issued tile address.
- cmp_ready  in  1  pipeline accepts tile.
- res_valid  in  1  commit-stage result, one-cycle pulse, in issue order.
- res_compressable  in  1  compressable bit from commit stage.
- res_flag  in  2  commit flag.
- rsp_valid  out  NUM_REQ  one-hot result strobe to the owning requester.
- rsp_compressable  out  1  registered copy of the result bit.
- rsp_flag  out  2  registered copy of the result flag.
- flush  in  1  request drain; level-sensitive.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  inflight count nonzero, or state is not RUN.
- err  out  1  sticky: result arrived with the ID FIFO empty.

Behaviour:
- Reset values: all outputs 0, state RUN, rr_ptr 0, inflight 0, FIFO empty.
- Arbitration:
  - Eligible only when state is RUN and inflight < MAX_INFLIGHT.
  - Winner is the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - cmp_valid = eligible and any req_valid; cmp_addr = winner's slice.
  - req_ready[winner] = cmp_ready and eligible; this is the handshake cycle.
  - Zero-latency pass-through; no skid register.
- On handshake:
  - Push winner ID into the FIFO (depth MAX_INFLIGHT).
  - rr_ptr <= winner + 1, wrapping.
  - inflight increments.
- Requesters must hold req_valid and req_addr stable until req_ready. The winner may change between cycles while cmp_ready is low; the pipeline samples cmp_addr only on the handshake.
- Results:
  - On res_valid, pop the FIFO head ID, inflight decrements.
  - Next cycle: rsp_valid[ID] = 1 for one cycle; rsp_compressable and rsp_flag are registered copies (1-cycle latency).
  - Result path has no backpressure.
- Simultaneous handshake and res_valid: push and pop in the same cycle; inflight unchanged. This is legal when full: the handshake is blocked while full, so a pop while full frees a slot only in the next cycle.
- res_valid with FIFO empty: set err, no rsp_valid, inflight stays 0. err clears only on rst.
- State machine:
  - RUN -> DRAIN when flush = 1; no new grants from that cycle.
  - DRAIN -> DONE when inflight == 0, including the same cycle as the last pop.
  - DONE: flush_done = 1 for one cycle. Go to IDLE if flush is still 1, otherwise to RUN.
  - IDLE -> RUN when flush = 0.
- Reset mid-operation: FIFO and counter clear immediately. Results still in the pipeline after reset set err if they arrive; the pipeline must be reset together with this block.

Optional Feature:
- Macro: COMPRESS_SCHED_STATS_EN.
- With it: 32-bit saturating counters stat_issued, stat_compressed (rsp with compressable = 1), and stat_raw.
  - Exposed as output ports; cleared on rst.
  - Incremented on the handshake and rsp_valid events respectively.
- Without it: the ports and logic do not exist; all other behaviour is identical.

Decomposition:
- Add to the types package:
  - sched_state_t enum {RUN, DRAIN, DONE, IDLE}.
  - localparam SCHED_ID_W = $clog2(NUM_REQ), for max 8.
- Sub-module sched_id_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by DEPTH and WIDTH, same clk/rst. Same-cycle push+pop when full is not required.

Test Plan:
- Single requester 2 issues addr 0x100, res_valid 3 cycles later with compressable = 1, flag = 2'b01 -> rsp_valid = 4'b0100 for exactly one cycle, rsp_flag = 01, inflight back to 0.
- All 4 requesters valid continuously, cmp_ready = 1 -> grant order 0,1,2,3, then stall at MAX_INFLIGHT = 4; one res_valid -> rsp to requester 0, then requester 0 granted again.
- cmp_ready low 5 cycles with requesters 1 and 3 valid -> req_ready stays 0; cmp_ready rises -> requester 1 granted, then requester 3.
- Three tiles in flight, flush = 1 -> no further grants; after three res_valid pulses, flush_done pulses once; flush held -> state IDLE; flush low -> grants resume.
- res_valid with nothing in flight -> err = 1 and stays 1; no rsp_valid asserted.
- Handshake and res_valid in the same cycle at inflight = 2 -> inflight stays 2, FIFO order preserved; responses match issue order.
